axi_lite_master_fifo: RTL

- AXI4-Lite master: the initiator counterpart of the team's FIFO-backed AXI-lite slave.
- User logic issues single-beat read/write commands through a valid/ready command port.
- Write data is staged in an internal write FIFO; read data returns through an internal read FIFO.
- Sits between a user accelerator and an AXI-lite interconnect (e.g. control registers of a peer block).

---
 rtl/axi_lite_master_fifo_if.sv | 44 ++++
 rtl/axi_lite_master_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_fifo_if.sv
// AXI4-Lite bus bundle for axi_lite_master_fifo.
//   master modport: drives AW/W/AR channels and BREADY/RREADY
//   slave  modport: drives AWREADY/WREADY/ARREADY and the B/R channels
// Signal names keep the M_AXI_* prefix of the original flat port list.
interface axi_lite_master_fifo_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_master_fifo.sv
// AXI4-Lite master with FIFO-staged write data and FIFO-returned read data.
// User logic issues single-beat read/write commands (user_addr + enables,
// accepted when user_ready is high); write data is pushed beforehand or
// afterwards through user_write_enq, read data pops via user_read_deq
// (first-word fall-through). user_done/user_error pulse once per completed
// B or R handshake.
// Ports: ACLK, ARESETN (async active-low), user_* command/data ports,
//        m_axi (AXI4-Lite master modport of axi_lite_master_fifo_if).
// Optional: define AXI_LITE_MASTER_ERR_COUNT_EN to add err_count[15:0],
//           a saturating count of user_error pulses.
module axi_lite_master_fifo #(
  parameter int unsigned FIFO_ADDR_WIDTH    = 4,
  parameter int unsigned USER_ADDR_WIDTH    = 8,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          user_write_enq,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] user_write_data,
  output logic                          user_write_almost_full,
  input  logic                          user_read_deq,
  output logic [C_M_AXI_DATA_WIDTH-1:0] user_read_data,
  output logic                          user_read_empty,
  input  logic [USER_ADDR_WIDTH-1:0]    user_addr,
  input  logic                          user_read_enable,
  input  logic                          user_write_enable,
  output logic                          user_ready,
  output logic                          user_done,
  output logic                          user_error,
  axi_lite_master_fifo_if.master        m_axi
`ifdef AXI_LITE_MASTER_ERR_COUNT_EN
  , output logic [15:0]                 err_count
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 3);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t state;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, next_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, done_q, error_q;

  logic [C_M_AXI_DATA_WIDTH-1:0] wf_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]    wf_wr_ptr, wf_rd_ptr;
  logic [CW-1:0]                 wf_count;
  logic                          wf_empty, wf_full, wf_push, wf_pop, wf_bypass;

  logic [C_M_AXI_DATA_WIDTH-1:0] rf_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]    rf_wr_ptr, rf_rd_ptr;
  logic [CW-1:0]                 rf_count;
  logic                          rf_empty, rf_full, rf_push, rf_pop, rready;

  assign next_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(user_addr);
  assign wf_empty  = (wf_count == '0);
  assign wf_full   = (wf_count == FULL_CNT);
  assign rf_empty  = (rf_count == '0);
  assign rf_full   = (rf_count == FULL_CNT);
  assign rready    = (state == RD_DATA) && !rf_full;

  // A word enqueued while WR_WAIT sits on an empty FIFO goes straight to
  // the WDATA register so AW/W rise one cycle after that enqueue.
  always_comb begin
    wf_bypass = (state == WR_WAIT) && wf_empty && user_write_enq;
    wf_pop    = !wf_empty && ((state == WR_WAIT) ||
                ((state == IDLE) && !user_read_enable && user_write_enable));
    wf_push   = user_write_enq && !wf_full && !wf_bypass;
    rf_push   = m_axi.M_AXI_RVALID && rready;
    rf_pop    = user_read_deq && !rf_empty;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (user_read_enable) begin
            addr_q    <= next_addr;
            arvalid_q <= 1'b1;
            state     <= RD_ADDR;
          end else if (user_write_enable) begin
            addr_q <= next_addr;
            if (!wf_empty) begin
              wdata_q   <= wf_mem[wf_rd_ptr];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_ADDR;
            end else begin
              state <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          if (!wf_empty || user_write_enq) begin
            wdata_q   <= wf_empty ? user_write_data : wf_mem[wf_rd_ptr];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (m_axi.M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi.M_AXI_AWREADY) && (!wvalid_q || m_axi.M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.M_AXI_BVALID) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= (m_axi.M_AXI_BRESP != 2'b00);
            state    <= IDLE;
          end
        end
        RD_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rf_push) begin
            done_q  <= 1'b1;
            error_q <= (m_axi.M_AXI_RRESP != 2'b00);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wf_wr_ptr <= '0;
      wf_rd_ptr <= '0;
      wf_count  <= '0;
      rf_wr_ptr <= '0;
      rf_rd_ptr <= '0;
      rf_count  <= '0;
    end else begin
      if (wf_push) wf_wr_ptr <= wf_wr_ptr + 1'b1;
      if (wf_pop)  wf_rd_ptr <= wf_rd_ptr + 1'b1;
      case ({wf_push, wf_pop})
        2'b10:   wf_count <= wf_count + 1'b1;
        2'b01:   wf_count <= wf_count - 1'b1;
        default: ;
      endcase
      if (rf_push) rf_wr_ptr <= rf_wr_ptr + 1'b1;
      if (rf_pop)  rf_rd_ptr <= rf_rd_ptr + 1'b1;
      case ({rf_push, rf_pop})
        2'b10:   rf_count <= rf_count + 1'b1;
        2'b01:   rf_count <= rf_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (wf_push) wf_mem[wf_wr_ptr] <= user_write_data;
    if (rf_push) rf_mem[rf_wr_ptr] <= m_axi.M_AXI_RDATA;
  end

`ifdef AXI_LITE_MASTER_ERR_COUNT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                       err_count <= '0;
    else if (error_q && err_count != '1) err_count <= err_count + 16'd1;
  end
`endif

  assign user_ready             = ARESETN && (state == IDLE);
  assign user_done              = done_q;
  assign user_error             = error_q;
  assign user_write_almost_full = (wf_count >= AFULL_CNT);
  assign user_read_empty        = rf_empty;
  assign user_read_data         = rf_mem[rf_rd_ptr];

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready;

endmodule
